// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : uart_pkg                                                   |
// | Brief   : Shared types and helpers for the UART transmitter family   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  // Wide enough for up to 9 data bits or 2 stop bits.
  localparam int BIT_CNT_W = $clog2(10);

  function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + ((parity != 0) ? 1 : 0) + stop_bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : uart_tx_fifo_if                                            |
// | Brief   : AXI-Stream style ready/valid word channel                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface uart_tx_fifo_if #(
  parameter int DATA_BITS = 8
);
  logic                 tvalid;
  logic [DATA_BITS-1:0] tdata;
  logic                 tready;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : sync_fifo                                                  |
// | Brief   : Single-clock FIFO with full/empty/count, async reset       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  wire logic                       clk,
  input  wire logic                       rst,
  input  wire logic                       wr_en_i,
  input  wire logic [WIDTH-1:0]           wr_data_i,
  input  wire logic                       rd_en_i,
  output logic      [WIDTH-1:0]           rd_data_o,
  output logic                            full_o,
  output logic                            empty_o,
  output logic      [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign do_push   = wr_en_i && !full_o;
  assign do_pop    = rd_en_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : uart_tx_fifo                                               |
// | Brief   : FIFO-buffered UART transmitter, back-to-back framing       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int NCLKS_PER_BIT = 217,
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1,
  parameter int FIFO_DEPTH    = 4
) (
  input  wire logic                            clk,
  input  wire logic                            rst,
  uart_tx_fifo_if.slave                        axis_in,
  output logic                                 tx_data,
  output logic                                 tx_busy,
  output logic                                 tx_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count
);

  localparam int                   BAUD_W    = $clog2(NCLKS_PER_BIT);
  localparam logic [BAUD_W-1:0]    BAUD_LAST = BAUD_W'(NCLKS_PER_BIT - 1);
  localparam logic [BIT_CNT_W-1:0] DATA_LAST = BIT_CNT_W'(DATA_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] STOP_LAST = BIT_CNT_W'(STOP_BITS - 1);
  localparam parity_e              PAR_MODE  = parity_e'(PARITY);

  tx_state_e              state_q, state_d;
  logic [BAUD_W-1:0]      baud_q, baud_d;
  logic [BIT_CNT_W-1:0]   bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   tx_q, tx_d;
  logic                   pop;
  logic                   bit_end;
  logic                   fifo_full, fifo_empty;
  logic [DATA_BITS-1:0]   fifo_rdata;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (axis_in.tvalid),
    .wr_data_i (axis_in.tdata),
    .rd_en_i   (pop),
    .rd_data_o (fifo_rdata),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  assign axis_in.tready = !fifo_full;
  assign bit_end        = (baud_q == BAUD_LAST);
  assign tx_data        = tx_q;
  assign tx_busy        = (state_q != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = (state_q == IDLE || bit_end) ? '0 : baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    tx_done = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        pop  = !fifo_empty;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          par_d   = par_q ^ shift_q[0];
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (PAR_MODE == PAR_NONE) begin
              state_d = STOP;
              tx_d    = 1'b1;
            end else begin
              // The local PARITY parameter hides the state name, hence the scope.
              state_d = uart_pkg::PARITY;
              tx_d    = (PAR_MODE == PAR_ODD) ? ~(par_q ^ shift_q[0]) : (par_q ^ shift_q[0]);
            end
          end else begin
            bit_d = bit_q + 1'b1;
            tx_d  = shift_d[0];
          end
        end
      end
      uart_pkg::PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            tx_done = 1'b1;
            pop     = !fifo_empty;
            state_d = IDLE;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Loading the next word is shared by the idle start and back-to-back paths.
    if (pop) begin
      state_d = START;
      shift_d = fifo_rdata;
      par_d   = 1'b0;
      bit_d   = '0;
      tx_d    = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_uart_tx_fifo                                            |
// | Brief   : Two UART configurations checked against a frame-level model|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_uart_tx_fifo;

  localparam int NB [2] = '{4, 3};
  localparam int DB [2] = '{8, 7};
  localparam int PB [2] = '{1, 2};
  localparam int SB [2] = '{2, 1};
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       tv0 = 1'b0, tv1 = 1'b0;
  logic [7:0] td0 = '0;
  logic [6:0] td1 = '0;
  logic       txd0, txd1, txb0, txb1, txdn0, txdn1;
  logic [2:0] fc0, fc1;

  uart_tx_fifo_if #(.DATA_BITS(8)) if0 ();
  uart_tx_fifo_if #(.DATA_BITS(7)) if1 ();
  assign if0.tvalid = tv0;
  assign if0.tdata  = td0;
  assign if1.tvalid = tv1;
  assign if1.tdata  = td1;

  uart_tx_fifo #(.NCLKS_PER_BIT(NB[0]), .DATA_BITS(DB[0]), .PARITY(PB[0]),
                 .STOP_BITS(SB[0]), .FIFO_DEPTH(DEPTH)) dut0 (
    .clk(clk), .rst(rst), .axis_in(if0.slave), .tx_data(txd0),
    .tx_busy(txb0), .tx_done(txdn0), .fifo_count(fc0));

  uart_tx_fifo #(.NCLKS_PER_BIT(NB[1]), .DATA_BITS(DB[1]), .PARITY(PB[1]),
                 .STOP_BITS(SB[1]), .FIFO_DEPTH(DEPTH)) dut1 (
    .clk(clk), .rst(rst), .axis_in(if1.slave), .tx_data(txd1),
    .tx_busy(txb1), .tx_done(txdn1), .fifo_count(fc1));

  int checks = 0;
  int errors = 0;

  task automatic check(input int u, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL u%0d %s: got %0d expected %0d at %0t", u, nm, act, exp, $time);
    end
  endtask

  // Frame-level model: accepted-word queue plus position inside the current frame.
  int          mq [2][64];
  int          mh [2];
  int          mt [2];
  bit          mbusy [2];
  int          mcyc [2];
  logic [15:0] mfrm [2];

  function automatic int frame_len(input int i);
    return (1 + DB[i] + ((PB[i] != 0) ? 1 : 0) + SB[i]) * NB[i];
  endfunction

  function automatic logic [15:0] frame_of(input int i, input int w);
    logic [15:0] f;
    logic        p;
    f    = '1;
    f[0] = 1'b0;
    p    = 1'b0;
    for (int b = 0; b < DB[i]; b++) begin
      f[1+b] = w[b];
      p      = p ^ w[b];
    end
    if (PB[i] == 1) f[1+DB[i]] = p;
    if (PB[i] == 2) f[1+DB[i]] = ~p;
    return f;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int cnt;
      bit acc;
      int w;
      if (rst) begin
        mh[i] = 0; mt[i] = 0; mbusy[i] = 1'b0; mcyc[i] = 0;
      end else begin
        cnt = mt[i] - mh[i];
        acc = ((i == 0) ? tv0 : tv1) && (cnt < DEPTH);
        w   = (i == 0) ? int'(td0) : int'(td1);
        if (!mbusy[i] || mcyc[i] == frame_len(i) - 1) begin
          if (cnt > 0) begin
            mfrm[i]  = frame_of(i, mq[i][mh[i] % 64]);
            mh[i]++;
            mbusy[i] = 1'b1;
            mcyc[i]  = 0;
          end else begin
            mbusy[i] = 1'b0;
          end
        end else begin
          mcyc[i]++;
        end
        if (acc) begin
          mq[i][mt[i] % 64] = w;
          mt[i]++;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic a_d, a_b, a_dn, a_r, e_d, e_b, e_dn, e_r;
      int   a_c, e_c;
      a_d  = (i == 0) ? txd0  : txd1;
      a_b  = (i == 0) ? txb0  : txb1;
      a_dn = (i == 0) ? txdn0 : txdn1;
      a_r  = (i == 0) ? if0.tready : if1.tready;
      a_c  = (i == 0) ? int'(fc0) : int'(fc1);
      if (rst) begin
        e_d = 1'b1; e_b = 1'b0; e_dn = 1'b0; e_c = 0; e_r = 1'b1;
      end else begin
        e_b  = mbusy[i];
        e_d  = mbusy[i] ? mfrm[i][mcyc[i] / NB[i]] : 1'b1;
        e_dn = mbusy[i] && (mcyc[i] == frame_len(i) - 1);
        e_c  = mt[i] - mh[i];
        e_r  = (e_c < DEPTH);
      end
      check(i, "tx_data", 32'(a_d), 32'(e_d));
      check(i, "tx_busy", 32'(a_b), 32'(e_b));
      check(i, "tx_done", 32'(a_dn), 32'(e_dn));
      check(i, "fifo_count", 32'(a_c), 32'(e_c));
      check(i, "tready", 32'(a_r), 32'(e_r));
    end
  end

  logic l0 [60], l1 [60], b0 [60];
  int   bc0, bc1, n0, n1, idle_busy, idle_low;
  bit   found, drained;

  task automatic drive_random(input int cycles, input int dens);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      tv0 = ($urandom_range(0, 99) < dens);
      td0 = 8'($urandom);
      tv1 = ($urandom_range(0, 99) < dens);
      td1 = 7'($urandom);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // One 0x07 into each idle transmitter, line recorded from the accepting edge on.
    @(posedge clk); #1;
    tv0 = 1'b1; tv1 = 1'b1; td0 = 8'h07; td1 = 7'h07;
    @(posedge clk); #1;
    tv0 = 1'b0; tv1 = 1'b0;
    bc0 = 0; bc1 = 0; n0 = 0; n1 = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      l0[c] = txd0; l1[c] = txd1; b0[c] = txb0;
      bc0 += int'(txb0); bc1 += int'(txb1);
      n0  += int'(txdn0); n1 += int'(txdn1);
    end
    check(0, "lit idle_latency", 32'(l0[0]), 32'd1);
    check(0, "lit start_bit", 32'(l0[1]), 32'd0);
    check(0, "lit data_bit0", 32'(l0[6]), 32'd1);
    check(0, "lit data_bit3", 32'(l0[18]), 32'd0);
    check(0, "lit even_parity", 32'(l0[38]), 32'd1);
    check(0, "lit last_stop", 32'(l0[48]), 32'd1);
    check(0, "lit busy_last", 32'(b0[48]), 32'd1);
    check(0, "lit busy_after", 32'(b0[49]), 32'd0);
    check(0, "lit frame_cycles", 32'(bc0), 32'd48);
    check(0, "lit done_pulses", 32'(n0), 32'd1);
    check(1, "lit start_bit", 32'(l1[1]), 32'd0);
    check(1, "lit odd_parity", 32'(l1[26]), 32'd0);
    check(1, "lit frame_cycles", 32'(bc1), 32'd30);
    check(1, "lit done_pulses", 32'(n1), 32'd1);

    drive_random(600, 90);
    drive_random(600, 15);
    drive_random(600, 60);
    drive_random(600, 5);

    // Reset in the middle of a frame's data bits with words still queued.
    found = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      tv0 = 1'b1; td0 = 8'($urandom);
      tv1 = 1'b1; td1 = 7'($urandom);
      if (mbusy[0] && mcyc[0] >= 2 * NB[0] && mcyc[0] < 8 * NB[0] && (mt[0] - mh[0]) >= 2) begin
        found = 1'b1;
        break;
      end
    end
    check(0, "rst_window_found", 32'(found), 32'd1);
    rst = 1'b1; tv0 = 1'b0; tv1 = 1'b0;
    #1;
    check(0, "rst tx_data", 32'(txd0), 32'd1);
    check(0, "rst tx_busy", 32'(txb0), 32'd0);
    check(0, "rst fifo_count", 32'(fc0), 32'd0);
    check(0, "rst tready", 32'(if0.tready), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle_busy = 0; idle_low = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      idle_busy += int'(txb0) + int'(txb1);
      idle_low  += int'(!txd0) + int'(!txd1);
    end
    check(0, "post_rst busy_cycles", 32'(idle_busy), 32'd0);
    check(0, "post_rst low_cycles", 32'(idle_low), 32'd0);

    drive_random(500, 80);

    @(posedge clk); #1;
    tv0 = 1'b0; tv1 = 1'b0;
    drained = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!txb0 && !txb1 && fc0 == 3'd0 && fc1 == 3'd0) begin
        drained = 1'b1;
        break;
      end
    end
    check(0, "drained", 32'(drained), 32'd1);
    check(0, "all_words_sent", 32'(mt[0] - mh[0]), 32'd0);
    check(1, "all_words_sent", 32'(mt[1] - mh[1]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
